full_sub: RTL and testbench



---
 rtl/full_sub_if.sv | 25 ++
 rtl/full_sub.sv | 59 +++++
 tb/tb_full_sub.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/full_sub_if.sv
// Full-subtractor port bundle: operand/enable inputs and all result outputs.
interface full_sub_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             a;
  logic             b;
  logic             c;
  logic             diff;
  logic             borrow;
  logic             diff_q;
  logic             borrow_q;
  logic [CNT_W-1:0] borrow_cnt;
  logic             err;

  modport master (
    output en, a, b, c,
    input  diff, borrow, diff_q, borrow_q, borrow_cnt, err
  );

  modport slave (
    input  en, a, b, c,
    output diff, borrow, diff_q, borrow_q, borrow_cnt, err
  );
endinterface

// File: rtl/full_sub.sv
// Single-bit full subtractor with a registered copy of the result and a
// saturating borrow counter.
// Optional macro FULL_SUB_SELFCHECK_EN adds an arithmetic cross-check that
// raises a sticky err flag; without it err is tied to 0.
module full_sub #(
  parameter int CNT_W = 8
) (
  input  logic    clk,
  input  logic    rst,
  full_sub_if.slave io
);
  logic             diff_c;
  logic             borrow_c;
  logic             diff_r;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;

  assign diff_c   = io.a ^ io.b ^ io.c;
  assign borrow_c = (~io.a & io.b) | (~io.a & io.c) | (io.b & io.c);

  assign io.diff       = diff_c;
  assign io.borrow     = borrow_c;
  assign io.diff_q     = diff_r;
  assign io.borrow_q   = borrow_r;
  assign io.borrow_cnt = cnt_r;

  // Result register and saturating borrow counter; reset wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r   <= 1'b0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else if (io.en) begin
      diff_r   <= diff_c;
      borrow_r <= borrow_c;
      if (borrow_c && (cnt_r != {CNT_W{1'b1}}))
        cnt_r <= cnt_r + 1'b1;
    end
  end

`ifdef FULL_SUB_SELFCHECK_EN
  logic [1:0] ref_sum;
  logic       err_r;

  // Reference computed with plain 2-bit arithmetic, independent of the gate equations.
  assign ref_sum = {1'b0, io.a} - {1'b0, io.b} - {1'b0, io.c};
  assign io.err  = err_r;

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      err_r <= 1'b0;
    else if (io.en && ({borrow_c, diff_c} != ref_sum))
      err_r <= 1'b1;
  end
`else
  assign io.err = 1'b0;
`endif
endmodule

// File: tb/tb_full_sub.sv
// Scoreboard bench for full_sub: expectations are queued when stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_full_sub;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct {
    logic             d;
    logic             br;
    logic             dq;
    logic             bq;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  typedef struct {
    logic d;
    logic br;
  } cexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t  reg_q[$];
  cexp_t comb_q[$];

  logic             m_dq  = 1'b0;
  logic             m_bq  = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  full_sub_if #(.CNT_W(CNT_W)) io ();

  full_sub #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: 2-bit two's-complement a-b-c, so borrow = sign, diff = lsb.
  function automatic logic [1:0] ref_sub(input logic a, input logic b, input logic c);
    int r;
    r = int'(a) - int'(b) - int'(c);
    return r[1:0];
  endfunction

  // One clocked step: drive on negedge, queue expected state, compare after posedge.
  task automatic step(input logic r, input logic e, input logic [2:0] abc, input string tag);
    exp_t x;
    exp_t g;
    logic [1:0] s;
    @(negedge clk);
    rst = r;
    io.en = e;
    {io.a, io.b, io.c} = abc;
    s = ref_sub(abc[2], abc[1], abc[0]);
    if (r) begin
      m_dq = 1'b0; m_bq = 1'b0; m_cnt = '0;
    end else if (e) begin
      m_dq = s[0]; m_bq = s[1];
      if (s[1] && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    end
    x.d = s[0]; x.br = s[1]; x.dq = m_dq; x.bq = m_bq; x.cnt = m_cnt; x.err = 1'b0;
    reg_q.push_back(x);
    @(posedge clk);
    #1;
    if (reg_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      g = reg_q.pop_front();
      chk({tag, "_diff"},     int'(io.diff),       int'(g.d));
      chk({tag, "_borrow"},   int'(io.borrow),     int'(g.br));
      chk({tag, "_diff_q"},   int'(io.diff_q),     int'(g.dq));
      chk({tag, "_borrow_q"}, int'(io.borrow_q),   int'(g.bq));
      chk({tag, "_cnt"},      int'(io.borrow_cnt), int'(g.cnt));
      chk({tag, "_err"},      int'(io.err),        int'(g.err));
    end
  endtask

  initial begin
    cexp_t ce;
    cexp_t cg;
    logic [1:0] s;
    logic [7:0] tbl_d  = 8'b1001_0110; // diff for abc=7..0
    logic [7:0] tbl_br = 8'b1000_1110; // borrow for abc=7..0
    io.en = 1'b0; io.a = 1'b0; io.b = 1'b0; io.c = 1'b0;

    // Reset state.
    step(1'b1, 1'b0, 3'b000, "reset");

    // Combinational sweep with registers held (en=0), checked against the truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {io.a, io.b, io.c} = v;
      ce.d = tbl_d[i]; ce.br = tbl_br[i];
      comb_q.push_back(ce);
      #5;
      cg = comb_q.pop_front();
      chk($sformatf("comb%0d_diff", i),   int'(io.diff),   int'(cg.d));
      chk($sformatf("comb%0d_borrow", i), int'(io.borrow), int'(cg.br));
      s = ref_sub(v[2], v[1], v[0]);
      chk($sformatf("comb%0d_arith", i),  int'({io.borrow, io.diff}), int'(s));
      #5;
    end

    // Registered latency.
    step(1'b1, 1'b0, 3'b000, "lat_rst");
    step(1'b0, 1'b1, 3'b001, "lat");

    // Hold with en=0.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b100, $sformatf("hold%0d", i));

    // Saturation: 1,2,3,3,3,3.
    step(1'b1, 1'b0, 3'b000, "sat_rst");
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 3'b111, $sformatf("sat%0d", i));

    // Reset mid-operation with en=1 and a borrowing input.
    step(1'b1, 1'b1, 3'b011, "mid_rst");
    step(1'b0, 1'b1, 3'b011, "resume");

    // All combinations with en=1: err must stay 0.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 3'(i), $sformatf("all%0d", i));

    // Random mix of en/rst/operands.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));

    chk("queue_empty", reg_q.size() + comb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
